stream_splitter: RTL and testbench
==================================

// Module: stream_splitter
// PURPOSE
//  Parametrised 1-to-N stream broadcaster; successor to the fixed 1-to-2 wire splitter.
//  Copies each accepted input beat to every enabled output channel, each with its own
//  1-entry output register. Each consumer drains independently (valid/ready per channel).
//  Sits between a single producer and N consumers that can stall independently.
// PARAMETERS
//  WIDTH    8   data bits per beat
//  N_OUT    2   output channel count (>=1)
//  CNT_W    16  width of saturating drop counter
// PORTS
//  clk        in   1            clock; all state updates on rising edge
//  rst        in   1            synchronous, active-high reset
//  chan_en    in   N_OUT        per-channel enable mask, sampled on input accept only
//  in_valid   in   1            producer beat valid
//  in_data    in   WIDTH        producer beat data
//  in_ready   out  1            block can accept this cycle (combinational)
//  out_valid  out  N_OUT        per-channel beat valid (registered)
//  out_data   out  N_OUT*WIDTH  per-channel data; channel i at [i*WIDTH +: WIDTH]
//  out_ready  in   N_OUT        per-channel consumer ready
//  drop_cnt   out  CNT_W        beats accepted with chan_en==0 (saturating)
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, out_data=0, drop_cnt=0; in-flight beats discarded.
//    rst overrides any same-cycle accept or drain.
//  - free[i] = !chan_en[i] | !out_valid[i] | out_ready[i]; in_ready = &free.
//    in_ready depends combinationally on out_ready and chan_en (no loop to in_valid).
//  - accept = in_valid & in_ready. Per channel i at edge:
//    accept & chan_en[i]            -> out_valid[i]=1, out_data[i]=in_data (load wins over drain)
//    else out_valid[i] & out_ready[i] -> out_valid[i]=0 (out_data held)
//    else hold.
//  - Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle when every
//    enabled channel is ready each cycle.
//  - Simultaneous drain + load on the same channel: out_valid stays 1, new data visible
//    next cycle, no bubble.
//  - Disabled channels are never loaded, but a beat already held drains normally.
//  - chan_en is sampled only at accept. Changes while beats are pending do not affect them.
//  - accept with chan_en==0: beat dropped, drop_cnt += 1, saturating at 2^CNT_W-1.
//  - out_valid[i] and out_data[i] must not change while out_valid[i]=1 & out_ready[i]=0.
//  - in_valid=0: no state change except drains. in_data is don't-care.
// STRUCTURE
//  - Package splitter_pkg: default parameter constants (SPLIT_WIDTH_DEF, SPLIT_NOUT_DEF,
//    SPLIT_CNTW_DEF) and typedef split_data_t = logic [WIDTH-1:0] (default width).
//  - Sub-module splitter_slot: 1-entry register (load, drain, valid, data).
//    Instantiated N_OUT times via a generate loop.
//  - Top: free/in_ready reduction, accept logic, drop counter.
// TESTING
//  Bench checks each rule above each cycle (scoreboard per channel). Directed scenarios:
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, drop_cnt=0, no load.
//  2 Broadcast: N_OUT=2, en=2'b11, out_ready=11, send 0xA5 -> both channels 0xA5
//    one cycle later; in_ready stays 1.
//  3 Independent stall: ch1 out_ready=0, send 0x11,0x22 -> 0x11 held on ch1, in_ready=0
//    on 2nd beat until ch1 drains; ch0 sees 0x11 once, then 0x22 after release.
//  4 Masking: en=2'b01, send 0x33 -> only ch0 valid. en=0, send 3 beats -> drop_cnt=3,
//    no out_valid.
//  5 Saturation: CNT_W=2, 5 drops -> drop_cnt=3.
//  6 Back-to-back + mid-stream reset: 8 beats, all ready -> 8 beats per channel in order;
//    rst mid-burst -> outputs cleared next cycle, stream resumes cleanly.

Source files
------------

// File: rtl/splitter_pkg.sv
// Shared constants and types for the 1-to-N stream splitter.
// Default width / channel count / drop-counter width and the beat data type.
package splitter_pkg;

  localparam int SPLIT_WIDTH_DEF = 8;
  localparam int SPLIT_NOUT_DEF  = 2;
  localparam int SPLIT_CNTW_DEF  = 16;

  typedef logic [SPLIT_WIDTH_DEF-1:0] split_data_t;

endpackage

// File: rtl/splitter_slot.sv
// One-entry output register for a single splitter channel.
// Ports: clk, rst (sync, active-high), load, drain, in_data -> valid, data.
module splitter_slot
  import splitter_pkg::*;
#(
  parameter int WIDTH = SPLIT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load wins over drain so a same-cycle refill leaves no bubble;
  // data is held on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_splitter.sv
// Parametrised 1-to-N stream broadcaster with per-channel output registers.
// Ports: clk, rst, chan_en, in_valid/in_data/in_ready, out_valid/out_data/out_ready, drop_cnt.
module stream_splitter
  import splitter_pkg::*;
#(
  parameter int WIDTH = SPLIT_WIDTH_DEF,
  parameter int N_OUT = SPLIT_NOUT_DEF,
  parameter int CNT_W = SPLIT_CNTW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_OUT-1:0]       chan_en,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT*WIDTH-1:0] out_data,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             accept;
  logic             drop;

  // A disabled channel never blocks the producer, even if it still
  // holds a stalled beat.
  assign free     = ~chan_en | ~out_valid | out_ready;
  assign in_ready = &free;
  assign accept   = in_valid & in_ready;
  assign load     = {N_OUT{accept}} & chan_en;
  assign drop     = accept & ~|chan_en;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    splitter_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[i]),
      .drain  (out_ready[i]),
      .in_data(in_data),
      .valid  (out_valid[i]),
      .data   (out_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != {CNT_W{1'b1}}) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_splitter.sv
// Directed self-checking bench for stream_splitter (N_OUT=2, WIDTH=8).
// A second instance with CNT_W=2 shares the stimulus to check counter saturation.
module tb_stream_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  chan_en;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_ready;
  logic [15:0] drop_cnt;

  logic        s_in_ready;
  logic [1:0]  s_out_valid;
  logic [15:0] s_out_data;
  logic [1:0]  s_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_splitter #(.WIDTH(8), .N_OUT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .chan_en(chan_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  stream_splitter #(.WIDTH(8), .N_OUT(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .chan_en(chan_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .drop_cnt(s_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    chan_en = 2'b11; out_ready = 2'b11;
    #1;
    // 1: reset with in_valid held high
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_sat_valid", 32'(s_out_valid), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'h0);

    // 2: broadcast
    in_valid = 1'b1; in_data = 8'hA5;
    #1 chk("bc_rdy", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bc_valid", 32'(out_valid), 32'h3);
    chk("bc_data", 32'(out_data), 32'hA5A5);
    chk("bc_sat_data", 32'(s_out_data), 32'hA5A5);
    #1 chk("bc_rdy2", 32'(in_ready), 32'h1);
    tick();
    chk("bc_drain", 32'(out_valid), 32'h0);

    // 3: independent stall on ch1
    out_ready = 2'b01; in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("st_valid1", 32'(out_valid), 32'h3);
    chk("st_data1", 32'(out_data), 32'h1111);
    in_data = 8'h22;
    #1 chk("st_rdy_lo", 32'(in_ready), 32'h0);
    tick();
    chk("st_valid2", 32'(out_valid), 32'h2);
    chk("st_hold1", 32'(out_data[15:8]), 32'h11);
    chk("st_rdy_lo2", 32'(in_ready), 32'h0);
    tick();
    chk("st_valid3", 32'(out_valid), 32'h2);
    chk("st_hold2", 32'(out_data[15:8]), 32'h11);
    out_ready = 2'b11;
    #1 chk("st_rdy_hi", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("st_valid4", 32'(out_valid), 32'h3);
    chk("st_data4", 32'(out_data), 32'h2222);
    tick();
    chk("st_drain", 32'(out_valid), 32'h0);

    // 4: masking and drops
    chan_en = 2'b01; in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    chk("mask_valid", 32'(out_valid), 32'h1);
    chk("mask_data", 32'(out_data), 32'h2233);
    tick();
    chan_en = 2'b00; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(k + 1);
      #1 chk("drop_rdy", 32'(in_ready), 32'h1);
      tick();
      chk("drop_valid", 32'(out_valid), 32'h0);
    end
    chk("drop_cnt3", 32'(drop_cnt), 32'h3);
    chk("sat_cnt3", 32'(s_drop_cnt), 32'h3);

    // 5: saturation of the 2-bit counter
    tick(); tick();
    in_valid = 1'b0;
    chk("drop_cnt5", 32'(drop_cnt), 32'h5);
    chk("sat_cnt5", 32'(s_drop_cnt), 32'h3);

    // disabled channel keeps and drains its stalled beat
    chan_en = 2'b11; out_ready = 2'b01; in_valid = 1'b1; in_data = 8'h44;
    tick();
    chan_en = 2'b01; in_data = 8'h55;
    #1 chk("dis_rdy", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("dis_valid", 32'(out_valid), 32'h3);
    chk("dis_data", 32'(out_data), 32'h4455);
    out_ready = 2'b11;
    tick();
    chk("dis_drain", 32'(out_valid), 32'h0);

    // 6: back-to-back burst with a reset mid-stream
    chan_en = 2'b11; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        rst = 1'b1; in_data = 8'hEE;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
        chk("mid_rst_sat", 32'(s_drop_cnt), 32'h0);
        rst = 1'b0;
      end
      in_data = 8'h80 + 8'(k);
      #1 chk("b2b_rdy", 32'(in_ready), 32'h1);
      tick();
      chk("b2b_valid", 32'(out_valid), 32'h3);
      chk("b2b_data", 32'(out_data), {16'h0, in_data, in_data});
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_end", 32'(out_valid), 32'h0);
    chk("b2b_drop", 32'(drop_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
